audio_mix_sched: RTL and testbench
==================================

// Module: audio_mix_sched
// PURPOSE
//  Time-multiplexed stereo mix scheduler for the MD/SMS audio path. Arbitrates up to four sample
//  sources (MD FM L/R pair, PSG, SMS FM, aux) onto one shared signed multiplier and accumulates
//  per-source L/R gain products. Emits one saturated stereo sample per sample_ce, ahead of the
//  genesis_lpf stage.
// PARAMETERS
//  N_SRC    4   number of requesters (2..8)
//  ACC_W    20  signed accumulator width per side
// PORTS
//  clk        in   1         system clock (53.69 MHz domain)
//  reset_n    in   1         asynchronous, active-low reset
//  sample_ce  in   1         output frame strobe, one clk wide (e.g. 48 kHz)
//  req        in   N_SRC     per-source request; held high with data stable until ack
//  ack        out  N_SRC     one-clk pulse: source contribution committed
//  src_data   in   16*N_SRC  signed sample per source, [16*i+:16]
//  gain_l     in   8*N_SRC   unsigned Q1.7 left gain per source (128 = unity, 255 = ~2x)
//  gain_r     in   8*N_SRC   unsigned Q1.7 right gain per source
//  mute_mask  in   N_SRC     1 = source granted and acked, contribution forced to 0
//  out_l      out  16        signed mixed left sample, updated on sample_ce
//  out_r      out  16        signed mixed right sample, updated on sample_ce
//  out_valid  out  1         one-clk pulse, cycle after sample_ce
// BEHAVIOUR
//  Reset: ack=0, out_l=out_r=0, out_valid=0, accumulators=0, RR pointer=0, FSM=IDLE.
//  FSM:
//   IDLE  -> LOAD   when any req. Round-robin pick, starting at pointer; pointer <= winner+1 mod N_SRC.
//   LOAD  -> MUL_L  latch data/gains/mute of winner.
//   MUL_L -> MUL_R  pl = (data * gain_l) >>> 7 (24b product, 17b result, arithmetic shift).
//   MUL_R -> COMMIT pr = (data * gain_r) >>> 7, same multiplier instance.
//   COMMIT -> LOAD if another req pending (excluding current winner), else -> IDLE.
//           Adds pl/pr, sign-extended to ACC_W, to the accumulators. ack[winner]=1 this cycle only.
//  Per-source latency: req seen in IDLE -> ack 4 clks later.
//  Throughput: 4 clks/source when back-to-back. No source is granted twice while another waits.
//  Commit is atomic: L and R are added in the same cycle; a half-pair is never visible.
//  sample_ce:
//   out_l/out_r <= sat16(acc + commit_term). commit_term is the COMMIT-cycle product, 0 otherwise.
//   acc <= 0. out_valid pulses next cycle.
//   A COMMIT coincident with sample_ce therefore lands in the frame being emitted.
//  Saturation: acc > 32767 -> 32767; acc < -32768 -> -32768. Accumulator itself never wraps for
//   N_SRC<=8 at ACC_W=20.
//  Source drops req before ack: latched contribution still committed and acked. Drop is a protocol
//   violation, flagged by assertion.
//  No req in a frame: output = 0.
//  A source re-requests the cycle after its ack: eligible, at lowest RR priority.
//  reset_n asserted mid-operation: everything returns to reset values at once. Pending contribution
//   is discarded and no ack is issued.
// CONFIGURATION
//  AUDIO_MIX_CLIPCNT_EN defined:
//   adds output clip_cnt [15:0]. Increments (saturating at 16'hFFFF) on each sample_ce where
//   out_l or out_r saturates. Cleared by reset_n only.
//  Undefined: no clip_cnt port, no counter logic; all other behaviour identical.
// STRUCTURE
//  audio_mix_pkg:
//   state enum mix_state_t {IDLE, LOAD, MUL_L, MUL_R, COMMIT}
//   GAIN_UNITY=8'd128, GAIN_SHIFT=7, SAMPLE_W=16, function sat16().
//  Sub-module audio_rr_arbiter: req + pointer -> one-hot grant + index, combinational, parameterised
//   by N_SRC.
//  Exactly one multiplier instance in audio_mix_sched.
// TESTING
//  1. Reset: reset_n low for 3 clks mid-MUL_R -> ack=0, out_l=out_r=0, next frame out=0.
//  2. Src0 data=1000, gain_l=128, gain_r=64, sample_ce after ack -> out_l=1000, out_r=500,
//     ack 4 clks after req.
//  3. All 4 req together, each 8000 @ gain 255 -> acks in order 0,1,2,3 at 4-clk spacing;
//     out_l=out_r=32767; clip_cnt=1 when AUDIO_MIX_CLIPCNT_EN is defined.
//  4. Fairness: src0,src1 re-request right after every ack for 40 clks -> grants alternate
//     0,1,0,1; src2 joins -> served within 12 clks.
//  5. sample_ce in src2 COMMIT cycle, data=-300, gain=128 -> that frame out_l=-300 with no other
//     sources; next frame out=0 with no req.
//  6. mute_mask[1]=1, src1 data=20000 -> ack[1] pulses at normal timing, out_l=out_r=0.

Source files
------------

// File: rtl/audio_mix_pkg.sv
// Shared types, constants and saturation helpers for the audio mix scheduler.
package audio_mix_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MUL_L, MUL_R, COMMIT} mix_state_t;

    localparam logic [7:0]  GAIN_UNITY = 8'd128;
    localparam int unsigned GAIN_SHIFT = 7;
    localparam int unsigned SAMPLE_W   = 16;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[SAMPLE_W-1:0];
    endfunction

    function automatic logic is_clip(input logic signed [31:0] v);
        return (v > 32'sd32767) || (v < -32'sd32768);
    endfunction

endpackage

// File: rtl/audio_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module audio_rr_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        logic [IDX_W-1:0] k;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            k = IDX_W'((32'(ptr) + i) % N_SRC);
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/audio_mix_sched.sv
// Time-multiplexed stereo mix scheduler: one shared multiplier, per-frame saturated output.
// Optional clip counter port enabled by defining AUDIO_MIX_CLIPCNT_EN.
module audio_mix_sched
    import audio_mix_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ACC_W = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sample_ce,
    input  logic [N_SRC-1:0]          req,
    output logic [N_SRC-1:0]          ack,
    input  logic [16*N_SRC-1:0]       src_data,
    input  logic [8*N_SRC-1:0]        gain_l,
    input  logic [8*N_SRC-1:0]        gain_r,
    input  logic [N_SRC-1:0]          mute_mask,
    output logic signed [15:0]        out_l,
    output logic signed [15:0]        out_r,
    output logic                      out_valid
`ifdef AUDIO_MIX_CLIPCNT_EN
    ,
    output logic [15:0]               clip_cnt
`endif
);

    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    mix_state_t state, state_next;

    logic [IDX_W-1:0]        winner, ptr, arb_idx;
    logic [N_SRC-1:0]        win_onehot, arb_req, arb_grant;
    logic                    arb_valid, grab;
    logic signed [15:0]      data_q;
    logic [7:0]              gl_q, gr_q, mul_gain;
    logic                    mute_q;
    logic signed [24:0]      prod;
    logic signed [16:0]      mul_res, pl, pr;
    logic signed [ACC_W-1:0] acc_l, acc_r, term_l, term_r, sum_l, sum_r;

    // The winner being committed is masked so a waiting source gets the next slot.
    always_comb begin
        arb_req = (state == COMMIT) ? (req & ~win_onehot) : req;
        grab    = ((state == IDLE) || (state == COMMIT)) && arb_valid;
    end

    audio_rr_arbiter #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_arb (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (arb_valid) state_next = LOAD;
            LOAD:    state_next = MUL_L;
            MUL_L:   state_next = MUL_R;
            MUL_R:   state_next = COMMIT;
            COMMIT:  state_next = arb_valid ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack    = (state == COMMIT) ? win_onehot : '0;
        term_l = '0;
        term_r = '0;
        if (state == COMMIT) begin
            term_l = ACC_W'(pl);
            term_r = ACC_W'(pr);
        end
        sum_l = acc_l + term_l;
        sum_r = acc_r + term_r;
    end

    // Single shared multiplier: left gain in MUL_L, right gain in MUL_R.
    always_comb begin
        mul_gain = (state == MUL_R) ? gr_q : gl_q;
        prod     = $signed(25'(data_q)) * $signed(25'({1'b0, mul_gain}));
        mul_res  = 17'(prod >>> GAIN_SHIFT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            winner     <= '0;
            win_onehot <= '0;
            ptr        <= '0;
            data_q     <= '0;
            gl_q       <= '0;
            gr_q       <= '0;
            mute_q     <= 1'b0;
            pl         <= '0;
            pr         <= '0;
        end else begin
            if (grab) begin
                winner     <= arb_idx;
                win_onehot <= arb_grant;
                ptr        <= (arb_idx == IDX_W'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (state == LOAD) begin
                data_q <= src_data[16*winner +: 16];
                gl_q   <= gain_l[8*winner +: 8];
                gr_q   <= gain_r[8*winner +: 8];
                mute_q <= mute_mask[winner];
            end
            if (state == MUL_L)
                pl <= mute_q ? '0 : mul_res;
            if (state == MUL_R)
                pr <= mute_q ? '0 : mul_res;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_l     <= '0;
            acc_r     <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= sample_ce;
            if (sample_ce) begin
                out_l <= sat16(32'(sum_l));
                out_r <= sat16(32'(sum_r));
                acc_l <= '0;
                acc_r <= '0;
            end else begin
                acc_l <= sum_l;
                acc_r <= sum_r;
            end
        end
    end

`ifdef AUDIO_MIX_CLIPCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            clip_cnt <= '0;
        else if (sample_ce && (is_clip(32'(sum_l)) || is_clip(32'(sum_r))) && (clip_cnt != 16'hFFFF))
            clip_cnt <= clip_cnt + 16'd1;
    end
`endif

    // A granted source must hold its request until the ack cycle.
    a_req_held: assert property (@(posedge clk) disable iff (!reset_n)
        (state != IDLE) |-> req[winner]);

endmodule

// File: tb/tb_audio_mix_sched.sv
// Bench for audio_mix_sched: directed scenarios plus random traffic against an ack-driven frame scoreboard.
module tb_audio_mix_sched;
    import audio_mix_pkg::*;

    localparam int N     = 4;
    localparam int BOUND = 4 * N + 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                sample_ce = 1'b0;
    logic [N-1:0]        req = '0;
    logic [N-1:0]        ack;
    logic [16*N-1:0]     src_data = '0;
    logic [8*N-1:0]      gain_l = '0;
    logic [8*N-1:0]      gain_r = '0;
    logic [N-1:0]        mute_mask = '0;
    logic signed [15:0]  out_l, out_r;
    logic                out_valid;
`ifdef AUDIO_MIX_CLIPCNT_EN
    logic [15:0]         clip_cnt;
`endif

    audio_mix_sched #(.N_SRC(N), .ACC_W(20)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_ce (sample_ce),
        .req       (req),
        .ack       (ack),
        .src_data  (src_data),
        .gain_l    (gain_l),
        .gain_r    (gain_r),
        .mute_mask (mute_mask),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid)
`ifdef AUDIO_MIX_CLIPCNT_EN
        ,
        .clip_cnt  (clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0, cyc = 0;
    logic rst_drv = 1'b0, sce_drv = 1'b0;
    logic want[N];
    int   d[N], gl[N], gr[N];
    logic mu[N];
    int   wait_c[N];
    int   fair_cnt[N][N];
    int   rereq_mode = 0;
    int   frame_l = 0, frame_r = 0, exp_l = 0, exp_r = 0, clip_exp = 0;
    logic pend = 1'b0;
    int   ack_cyc[$], ack_src[$];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int contrib(input int data, input int g, input logic m);
        int p;
        if (m) return 0;
        p = data * g;
        return (p >= 0) ? p / 128 : -((-p + 127) / 128);
    endfunction

    function automatic int satv(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic new_req(input int i, input int data, input int g_l, input int g_r, input logic m);
        want[i] = 1'b1; d[i] = data; gl[i] = g_l; gr[i] = g_r; mu[i] = m;
        wait_c[i] = 0;
        for (int j = 0; j < N; j++) fair_cnt[i][j] = 0;
    endtask

    task automatic rand_req(input int i);
        new_req(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            want[i] = 1'b0; wait_c[i] = 0; mu[i] = 1'b0; d[i] = 0; gl[i] = 0; gr[i] = 0;
            for (int j = 0; j < N; j++) fair_cnt[i][j] = 0;
        end
        frame_l = 0; frame_r = 0; pend = 1'b0; clip_exp = 0;
    endtask

    task automatic monitor();
        int worst;
        if (!reset_n) begin
            clear_model();
            return;
        end
        if (pend) begin
            pend = 1'b0;
            check("out_valid", int'(out_valid), 1);
            check("out_l", int'(out_l), exp_l);
            check("out_r", int'(out_r), exp_r);
`ifdef AUDIO_MIX_CLIPCNT_EN
            check("clip_cnt", int'(clip_cnt), clip_exp);
`endif
        end
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                ack_cyc.push_back(cyc);
                ack_src.push_back(i);
                check("ack_has_req", int'(want[i]), 1);
                check("ack_wait_ok", int'(wait_c[i] <= BOUND), 1);
                frame_l += contrib(d[i], gl[i], mu[i]);
                frame_r += contrib(d[i], gr[i], mu[i]);
                worst = 0;
                for (int j = 0; j < N; j++) begin
                    if (j != i && want[j]) begin
                        fair_cnt[j][i]++;
                        if (fair_cnt[j][i] > worst) worst = fair_cnt[j][i];
                    end
                end
                check("rr_fair", int'(worst <= 1), 1);
                if (rereq_mode == 1) new_req(i, d[i], gl[i], gr[i], mu[i]);
                else if (rereq_mode == 2 && $urandom_range(0, 1) == 1) rand_req(i);
                else want[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (want[i] && !ack[i]) begin
                wait_c[i]++;
                if (wait_c[i] > BOUND + 8) begin
                    check("req_wait", wait_c[i], BOUND);
                    want[i] = 1'b0;
                end
            end
        end
        if (sample_ce) begin
            exp_l = satv(frame_l);
            exp_r = satv(frame_r);
            if ((exp_l != frame_l || exp_r != frame_r) && clip_exp < 65535) clip_exp++;
            frame_l = 0; frame_r = 0; pend = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        reset_n   = rst_drv;
        sample_ce = sce_drv;
        for (int i = 0; i < N; i++) begin
            req[i]             = want[i];
            src_data[16*i +: 16] = 16'(d[i]);
            gain_l[8*i +: 8]   = 8'(gl[i]);
            gain_r[8*i +: 8]   = 8'(gr[i]);
            mute_mask[i]       = mu[i];
        end
        @(negedge clk);
        cyc++;
        monitor();
        sce_drv = 1'b0;
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        repeat (3) tick();
        rst_drv = 1'b1;
        tick();
        ack_cyc.delete();
        ack_src.delete();
    endtask

    task automatic wait_acks(input int n, input int limit);
        int k = 0;
        while (ack_cyc.size() < n && k < limit) begin
            tick();
            k++;
        end
        check("ack_count", ack_cyc.size(), n);
    endtask

    task automatic drain();
        int k = 0;
        logic any;
        rereq_mode = 0;
        any = 1'b1;
        while (any && k < 100) begin
            tick();
            k++;
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= want[i];
        end
        check("drained", int'(any), 0);
    endtask

    task automatic frame_out();
        sce_drv = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int c, c2, lat;
        logic found;
        clear_model();

        // 1: reset in the middle of MUL_R discards the pending contribution
        do_reset();
        new_req(0, 5000, GAIN_UNITY, GAIN_UNITY, 1'b0);
        repeat (3) tick();
        rst_drv = 1'b0;
        want[0] = 1'b0;
        repeat (3) begin
            tick();
            check("rst_ack", int'(ack), 0);
            check("rst_out_l", int'(out_l), 0);
            check("rst_out_r", int'(out_r), 0);
        end
        rst_drv = 1'b1;
        repeat (2) tick();
        frame_out();
        check("rst_no_ack", ack_cyc.size(), 0);
        check("rst_frame_l", int'(out_l), 0);

        // 2: single source, latency and gain scaling
        do_reset();
        new_req(0, 1000, GAIN_UNITY, 64, 1'b0);
        tick();
        c = cyc;
        wait_acks(1, 20);
        if (ack_cyc.size() > 0) begin
            check("t2_latency", ack_cyc[0] - c, 4);
            check("t2_src", ack_src[0], 0);
        end
        tick();
        frame_out();
        check("t2_out_l", int'(out_l), 1000);
        check("t2_out_r", int'(out_r), 500);

        // 3: all sources at once, order and saturation
        do_reset();
        for (int i = 0; i < N; i++) new_req(i, 8000, 255, 255, 1'b0);
        tick();
        c = cyc;
        wait_acks(4, 30);
        for (int i = 0; i < N && i < ack_cyc.size(); i++) begin
            check("t3_src", ack_src[i], i);
            check("t3_cyc", ack_cyc[i] - c, 4 * (i + 1));
        end
        tick();
        frame_out();
        check("t3_out_l", int'(out_l), 32767);
        check("t3_out_r", int'(out_r), 32767);
`ifdef AUDIO_MIX_CLIPCNT_EN
        check("t3_clip", int'(clip_cnt), 1);
`endif

        // 4: two sources re-requesting continuously alternate; a third is served promptly
        do_reset();
        rereq_mode = 1;
        new_req(0, 100, GAIN_UNITY, GAIN_UNITY, 1'b0);
        new_req(1, -50, GAIN_UNITY, GAIN_UNITY, 1'b0);
        tick();
        c = cyc;
        while (cyc < c + 40) tick();
        new_req(2, 77, GAIN_UNITY, GAIN_UNITY, 1'b0);
        tick();
        c2 = cyc;
        found = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            foreach (ack_src[e]) if (!found && ack_src[e] == 2) begin
                found = 1'b1;
                lat = ack_cyc[e] - c2;
            end
            if (!found) tick();
        end
        check("t4_src2_served", int'(found && lat <= 12), 1);
        if (ack_cyc.size() > 0) check("t4_first", ack_cyc[0] - c, 4);
        foreach (ack_src[e]) if (ack_cyc[e] < c2) check("t4_alt", ack_src[e], e % 2);
        drain();
        frame_out();

        // 5: sample_ce coincident with a COMMIT lands in that frame
        do_reset();
        new_req(2, -300, GAIN_UNITY, GAIN_UNITY, 1'b0);
        tick();
        c = cyc;
        repeat (3) tick();
        sce_drv = 1'b1;
        tick();
        check("t5_ack_cyc", (ack_cyc.size() > 0) ? ack_cyc[0] - c : -1, 4);
        tick();
        check("t5_out_l", int'(out_l), -300);
        repeat (5) tick();
        frame_out();
        check("t5_next_l", int'(out_l), 0);

        // 6: muted source is acked normally but contributes nothing
        do_reset();
        new_req(1, 20000, 200, 200, 1'b1);
        tick();
        c = cyc;
        wait_acks(1, 20);
        if (ack_cyc.size() > 0) begin
            check("t6_latency", ack_cyc[0] - c, 4);
            check("t6_src", ack_src[0], 1);
        end
        frame_out();
        check("t6_out_l", int'(out_l), 0);
        check("t6_out_r", int'(out_r), 0);

        // random traffic
        do_reset();
        rereq_mode = 2;
        repeat (3000) begin
            for (int i = 0; i < N; i++)
                if (!want[i] && $urandom_range(0, 7) == 0) rand_req(i);
            if ($urandom_range(0, 39) == 0) sce_drv = 1'b1;
            tick();
        end
        drain();
        tick();
        frame_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
